// File: rtl/mc_ctrl_pkg.sv
// ============================================================
// mc_ctrl_pkg: shared encodings for the multicycle ARM control unit
// Revision: 1.0
// ============================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_MULWAIT = 4'd10
  } state_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Without the wide encoding EOR has no code of its own and falls back to AND.
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd, input logic has_ext);
    logic [2:0] code;
    code = ALU_ADD;
    case (cmd)
      CMD_ADD:          code = ALU_ADD;
      CMD_SUB, CMD_CMP: code = ALU_SUB;
      CMD_AND:          code = ALU_AND;
      CMD_ORR:          code = ALU_ORR;
      CMD_EOR:          code = has_ext ? ALU_EOR : ALU_AND;
      default:          code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_cond_unit.sv
// ============================================================
// mc_cond_unit: NZCV flag register, one-cycle flag buffer and CondEx table
// Revision: 1.0
// ============================================================
`default_nettype none

module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Cond_i,
  input  logic [3:0] ALUFlags_i,
  input  logic       FlagW_i,
  output logic       CondEx_o
);

  logic [3:0] flags_q;
  logic [3:0] flagbuf_q;
  logic       w_n, w_z, w_c, w_v;

  // flagbuf_q always holds the ALU flags of the previous cycle, i.e. of the execute state.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      flags_q   <= 4'b0000;
      flagbuf_q <= 4'b0000;
    end else begin
      flagbuf_q <= ALUFlags_i;
      if (FlagW_i) flags_q <= flagbuf_q;
    end
  end

  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    CondEx_o = 1'b0;
    case (Cond_i)
      COND_EQ: CondEx_o = w_z;
      COND_NE: CondEx_o = ~w_z;
      COND_CS: CondEx_o = w_c;
      COND_CC: CondEx_o = ~w_c;
      COND_MI: CondEx_o = w_n;
      COND_PL: CondEx_o = ~w_n;
      COND_VS: CondEx_o = w_v;
      COND_VC: CondEx_o = ~w_v;
      COND_HI: CondEx_o = w_c & ~w_z;
      COND_LS: CondEx_o = ~w_c | w_z;
      COND_GE: CondEx_o = (w_n == w_v);
      COND_LT: CondEx_o = (w_n != w_v);
      COND_GT: CondEx_o = ~w_z & (w_n == w_v);
      COND_LE: CondEx_o = w_z | (w_n != w_v);
      COND_AL: CondEx_o = 1'b1;
      default: CondEx_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm_p.sv
// ============================================================
// mc_ctrl_fsm_p: parametrised multicycle ARM controller (FSM, ALU decode, flags)
// Revision: 1.0
// ============================================================
`default_nettype none

module mc_ctrl_fsm_p
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W  = 2,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [3:0]           Cond_i,
  input  logic [3:0]           ALUFlags_i,
  input  logic [1:0]           Op_i,
  input  logic [5:0]           Funct_i,
  input  logic [3:0]           Rd_i,
  input  logic                 IsMul_i,
  input  logic                 MemReady_i,
  output logic                 PCWrite_o,
  output logic                 RegWrite_o,
  output logic                 MemWrite_o,
  output logic                 IRWrite_o,
  output logic                 AdrSrc_o,
  output logic [1:0]           ResultSrc_o,
  output logic                 ALUSrcA_o,
  output logic [1:0]           ALUSrcB_o,
  output logic [1:0]           ImmSrc_o,
  output logic [1:0]           RegSrc_o,
  output logic [ALUCTRL_W-1:0] ALUCtrl_o,
  output logic                 MemReq_o,
  output logic [3:0]           State_o
);

  localparam bit              HAS_EXT  = (ALUCTRL_W >= 3);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mulcnt_q, mulcnt_d;

  logic       w_condex, w_flagw, w_is_cmp;
  logic [3:0] w_cmd;
  logic [2:0] w_alu_dp;
  logic       w_pcw, w_rw, w_mw, w_irw, w_mreq;
  logic [2:0] w_alu;

  assign w_cmd    = Funct_i[4:1];
  assign w_is_cmp = (w_cmd == CMD_CMP);
  assign w_alu_dp = alu_decode(w_cmd, HAS_EXT);
  assign w_flagw  = (state_q == S_ALUWB) & w_condex & (Funct_i[0] | w_is_cmp);

  mc_cond_unit u_cond (
    .clk        (clk),
    .Reset      (Reset),
    .Cond_i     (Cond_i),
    .ALUFlags_i (ALUFlags_i),
    .FlagW_i    (w_flagw),
    .CondEx_o   (w_condex)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_FETCH;
      mulcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mulcnt_q <= mulcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mulcnt_d    = mulcnt_q;
    w_pcw       = 1'b0;
    w_rw        = 1'b0;
    w_mw        = 1'b0;
    w_irw       = 1'b0;
    w_mreq      = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = 1'b0;
    ALUSrcB_o   = SRCB_RD2;
    w_alu       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        w_mreq      = 1'b1;
        ALUSrcA_o   = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURES;
        if (MemReady_i) begin
          w_irw   = 1'b1;
          w_pcw   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA_o   = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURES;
        if (Op_i == OP_MEM)                             state_d = S_MEMADR;
        else if (Op_i == OP_BR)                         state_d = S_BRANCH;
        else if (Op_i == OP_DP && Funct_i[5])           state_d = S_EXECI;
        else if (Op_i == OP_DP && IsMul_i && HAS_EXT) begin
          state_d  = S_MULWAIT;
          mulcnt_d = MUL_LOAD;
        end else                                        state_d = S_EXECR;
      end
      S_MEMADR: begin
        ALUSrcB_o = SRCB_IMM;
        state_d   = Funct_i[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mreq   = 1'b1;
        AdrSrc_o = 1'b1;
        if (MemReady_i) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc_o = 1'b1;
        // A store whose condition fails never issues a memory request.
        if (!w_condex) begin
          state_d = S_FETCH;
        end else begin
          w_mreq = 1'b1;
          w_mw   = 1'b1;
          if (MemReady_i) state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        ResultSrc_o = RES_DATA;
        w_rw        = w_condex;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        w_alu   = w_alu_dp;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB_o = SRCB_IMM;
        w_alu     = w_alu_dp;
        state_d   = S_ALUWB;
      end
      S_MULWAIT: begin
        w_alu = ALU_MUL;
        if (mulcnt_q == '0) state_d  = S_ALUWB;
        else                mulcnt_d = mulcnt_q - CNT_W'(1);
      end
      S_ALUWB: begin
        w_alu   = w_alu_dp;
        w_rw    = w_condex & ~w_is_cmp;
        w_pcw   = w_condex & ~w_is_cmp & (Rd_i == 4'd15);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB_o   = SRCB_IMM;
        ResultSrc_o = RES_ALURES;
        w_pcw       = w_condex;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are forced low while Reset is high, even though FETCH itself requests memory.
  assign PCWrite_o  = w_pcw  & ~Reset;
  assign RegWrite_o = w_rw   & ~Reset;
  assign MemWrite_o = w_mw   & ~Reset;
  assign IRWrite_o  = w_irw  & ~Reset;
  assign MemReq_o   = w_mreq & ~Reset;

  assign ALUCtrl_o = ALUCTRL_W'(w_alu);
  assign ImmSrc_o  = Op_i;
  assign RegSrc_o  = {Op_i == OP_MEM, Op_i == OP_BR};
  assign State_o   = state_q;

endmodule

`default_nettype wire
